// File: rtl/myhardware_hex_writer.sv
// Avalon-MM master that writes one active-low 7-segment code per HEX PIO digit.
// Optional leading-zero blanking is enabled by defining HEX_BLANK_LEADING_EN.
module myhardware_hex_writer #(
  parameter int unsigned          NUM_DIGITS = 6,
  parameter int unsigned          ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR  = '0,
  parameter int unsigned          STRIDE     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       avm_address,
  output logic                    avm_write,
  output logic [31:0]             avm_writedata,
  output logic [3:0]              avm_byteenable,
  input  logic                    avm_waitrequest
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {
    S_IDLE,
    S_WRITE
  } state_t;

  state_t                  state_q;
  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic [IDX_W-1:0]        index_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    write_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [6:0]              data_q;
  logic [3:0]              be_q;

  logic [IDX_W-1:0]        idx_nxt;
  logic [ADDR_W-1:0]       addr_nxt;
  logic [6:0]              seg_nxt;
  logic [6:0]              seg_first;
  logic                    last_digit;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] digit_code(input logic [4*NUM_DIGITS-1:0] v,
                                            input int unsigned i);
    logic [6:0] code;
    code = seg7(v[4*i +: 4]);
`ifdef HEX_BLANK_LEADING_EN
    // Blank digit i when it and every more-significant digit are zero.
    if ((i > 0) && ((v >> (4*i)) == '0)) code = 7'h7F;
`else
`endif
    return code;
  endfunction

  always_comb begin
    idx_nxt    = index_q + 1'b1;
    last_digit = (index_q == IDX_W'(NUM_DIGITS-1));
    addr_nxt   = BASE_ADDR + ADDR_W'(idx_nxt) * ADDR_W'(STRIDE);
    seg_first  = digit_code(value, 0);
    seg_nxt    = '0;
    if (!last_digit) seg_nxt = digit_code(shadow_q, 32'(idx_nxt));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      index_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      be_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // The done cycle sits in IDLE but must not accept a new start.
          if (start && !done_q) begin
            shadow_q <= value;
            index_q  <= '0;
            state_q  <= S_WRITE;
            busy_q   <= 1'b1;
            write_q  <= 1'b1;
            addr_q   <= BASE_ADDR;
            data_q   <= seg_first;
            be_q     <= 4'b0001;
          end
        end
        S_WRITE: begin
          if (!avm_waitrequest) begin
            if (last_digit) begin
              state_q <= S_IDLE;
              write_q <= 1'b0;
              be_q    <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              index_q <= idx_nxt;
              addr_q  <= addr_nxt;
              data_q  <= seg_nxt;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign avm_write      = write_q;
  assign avm_address    = addr_q;
  assign avm_writedata  = {25'b0, data_q};
  assign avm_byteenable = be_q;

endmodule
